// File: rtl/pc_stack16.sv
// pc_stack16 -- 16-bit program counter with a small return-address stack.
//
// Each cycle accepts one command, chosen by priority ret > call > load > inc > hold:
//   ret  : pop the most recent return address into pc (underflow flag if empty)
//   call : push pc+1, then jump to d (overflow flag if full)
//   load : jump to d
//   inc  : pc <= pc + 1 (wraps 16'hFFFF -> 16'h0000 silently)
//
// Ports
//   clk      in   1   clock, all state on rising edge
//   rst_n    in   1   synchronous active-low reset
//   inc      in   1   advance pc
//   load     in   1   jump to d
//   call     in   1   push pc+1, jump to d
//   ret      in   1   pop into pc
//   d        in  16   jump/call target
//   pc       out 16   program counter (registered)
//   full     out  1   stack holds DEPTH entries
//   empty    out  1   stack holds no entries
//   ovf_err  out  1   sticky: call attempted while full
//   unf_err  out  1   sticky: ret attempted while empty
module pc_stack16 #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        load,
  input  logic        call,
  input  logic        ret,
  input  logic [15:0] d,
  output logic [15:0] pc,
  output logic        full,
  output logic        empty,
  output logic        ovf_err,
  output logic        unf_err
);

  // sp counts 0..DEPTH inclusive, so it needs one more code than the entry index.
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_ONE   = SPW'(1);
  localparam logic [SPW-1:0] SP_ZERO  = SPW'(0);
  localparam logic [SPW-1:0] SP_DEPTH = SPW'(DEPTH);

  logic [15:0]    pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           push_s;
  logic [15:0]    pc_plus1_s;
  logic [SPW-1:0] sp_m1_s;
  logic [AW-1:0]  push_idx_s;
  logic [AW-1:0]  pop_idx_s;
  logic           full_s;
  logic           empty_s;

  logic [15:0]    stack_q [DEPTH];

  assign pc_plus1_s = pc_q + 16'd1;
  assign sp_m1_s    = sp_q - SP_ONE;
  // Indices are only used when sp is a legal slot (push: sp<DEPTH, pop: sp>0).
  assign push_idx_s = sp_q[AW-1:0];
  assign pop_idx_s  = sp_m1_s[AW-1:0];
  assign full_s     = (sp_q == SP_DEPTH);
  assign empty_s    = (sp_q == SP_ZERO);

  // Next-state decode with ret > call > load > inc > hold priority.
  always_comb begin
    pc_d   = pc_q;
    sp_d   = sp_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    push_s = 1'b0;
    if (ret) begin
      if (empty_s) begin
        unf_d = 1'b1;
      end else begin
        pc_d = stack_q[pop_idx_s];
        sp_d = sp_m1_s;
      end
    end else if (call) begin
      if (full_s) begin
        ovf_d = 1'b1;
      end else begin
        push_s = 1'b1;
        pc_d   = d;
        sp_d   = sp_q + SP_ONE;
      end
    end else if (load) begin
      pc_d = d;
    end else if (inc) begin
      pc_d = pc_plus1_s;
    end else begin
      pc_d = pc_q;
    end
  end

  // Control state: pc, stack pointer and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= 16'h0000;
      sp_q  <= SP_ZERO;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage: no reset needed, entries at or above sp are never read.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      stack_q[push_idx_s] <= pc_plus1_s;
    end
  end

  assign pc      = pc_q;
  assign full    = full_s;
  assign empty   = empty_s;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule

// File: doc/pc_stack16.md
PC_STACK16 -- requirements
Module: pc_stack16

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the return-address stack entries (2..16).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset sampled on rising clk.
REQ-004 inc  input  1  advance pc by one.
REQ-005 load  input  1  jump: pc takes d.
REQ-006 call  input  1  push pc+1 onto the stack; pc takes d.
REQ-007 ret  input  1  pop the stack top into pc.
REQ-008 d  input  16  jump/call target address.
REQ-009 pc  output  16  current program counter (registered).
REQ-010 full  output  1  high when the stack holds DEPTH entries.
REQ-011 empty  output  1  high when the stack holds 0 entries.
REQ-012 ovf_err  output  1  sticky: a call was attempted while full.
REQ-013 unf_err  output  1  sticky: a ret was attempted while empty.

Function
REQ-014 Command priority per cycle SHALL be ret > call > load > inc > hold; lower-priority commands asserted in the same cycle SHALL be ignored.
REQ-015 pc SHALL change only on a rising clk edge; the new value SHALL be visible one cycle after the command is sampled (latency 1).
REQ-016 inc SHALL set pc to (pc+1) mod 2^16; 16'hFFFF SHALL wrap to 16'h0000 with no flag.
REQ-017 load SHALL set pc to d; stack, full and empty SHALL be unchanged.
REQ-018 call when not full SHALL write (pc+1) mod 2^16 into the entry at the stack pointer, increment the stack pointer, and set pc to d, all in the same edge.
REQ-019 call when full SHALL leave pc and stack unchanged and set ovf_err to 1.
REQ-020 ret when not empty SHALL set pc to the most recently pushed entry and decrement the stack pointer.
REQ-021 ret when empty SHALL leave pc and stack unchanged and set unf_err to 1.
REQ-022 Because ret outranks call, a cycle with both asserted SHALL be a pure pop (or an underflow when empty).
REQ-023 The stack pointer SHALL range 0..DEPTH; full SHALL be (sp==DEPTH) and empty SHALL be (sp==0), both decoded combinationally from the registered sp.
REQ-024 ovf_err and unf_err, once set, SHALL remain 1 until reset; they SHALL NOT block further commands.
REQ-025 With no command asserted, pc, sp and all flags SHALL hold.
REQ-026 Stack entry contents SHALL be don't-care when not below sp; only entries 0..sp-1 are architecturally visible through ret.

Reset
REQ-027 When rst_n is sampled low, pc SHALL become 16'h0000, sp SHALL become 0, empty SHALL be 1, full SHALL be 0, and ovf_err and unf_err SHALL be 0, regardless of any command asserted that cycle.
REQ-028 Reset asserted mid-sequence (e.g. between a call and its ret) SHALL discard all stacked addresses; a following ret SHALL underflow.
REQ-029 Stack storage SHALL NOT need a reset value.

Verification
REQ-030 Reset, then inc for 3 cycles -> pc reads 1, 2, 3 on successive cycles; empty=1 throughout.
REQ-031 load d=16'hFFFF, then inc -> pc=16'hFFFF then 16'h0000; no flag set.
REQ-032 pc=16'h0010, call d=16'h0200, then call d=16'h0300, then ret, then ret -> pc=0x0200, 0x0300, 0x0201, 0x0011; empty=1 at end.
REQ-033 DEPTH=4: five calls from pc=0 with d=0x0100..0x0104 -> after fourth full=1; fifth leaves pc=0x0103 and sets ovf_err=1; four rets then yield 0x0103, 0x0102, 0x0101, 0x0001.
REQ-034 From reset, ret with call, load and inc all asserted -> pc stays 0, unf_err=1; a subsequent inc still advances pc to 1 and unf_err stays 1.
REQ-035 Push two entries, assert rst_n low with call asserted -> pc=0, empty=1, flags 0; next ret sets unf_err=1 and pc stays 0.
